limits_buffer_ctrl: RTL
=======================

Name: limits_buffer_ctrl

Overview:
Limits buffer controller sitting directly upstream of the hard limiter. It stores one packet of per-sample {max,min} limit pairs in an internal RAM, loaded over a streaming interface. On each iteration start it replays the pairs in lock-step with the FIR samples the limiter consumes, driving limbuff_data/limbuff_valid.

Parameters:
ADDR_WIDTH, 10, log2 of RAM depth (DEPTH = 2**ADDR_WIDTH entries of 32 bits)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
load_data  in  32  limit pair: [31:16] max, [15:0] min (signed 16-bit each)
load_valid  in  1  load beat valid
load_sop  in  1  first beat of limits packet
load_eop  in  1  last beat of limits packet
load_ready  out  1  controller accepts load beats
iter_new_signal  in  1  single-cycle pulse: start replay from entry 0
adv_valid  in  1  FIR sample valid (tap of fir.valid)
adv_ready  in  1  FIR sample accepted (tap of fir.ready)
limbuff_data  out  32  current limit pair to the limiter
limbuff_valid  out  1  limbuff_data valid for the current FIR sample
limbuff_count  out  ADDR_WIDTH+1  entries in last completed packet
limbuff_error  out  1  sticky load overflow flag

Behaviour:
- One clock; reset synchronous and active-high. Reset mid-operation aborts load/replay at once.
- Reset values: state IDLE, limbuff_data 0, limbuff_valid 0, limbuff_count 0, limbuff_error 0, load_ready 0 while reset is high. RAM contents are not reset.
- States: IDLE, LOAD, PRIME, REPLAY.
- load_ready = 1 in IDLE and LOAD, 0 otherwise (combinational from state). A beat transfers on load_valid & load_ready.
- IDLE: a beat with load_sop -> write mem[0], wr_ptr=1, clear limbuff_error, go LOAD (a single sop+eop beat completes immediately: count=1, stay IDLE). A beat without sop is dropped.
- LOAD: each beat writes mem[wr_ptr], wr_ptr++. A beat with sop restarts at address 0. On an eop beat: limbuff_count <= entries written (saturated at DEPTH), go IDLE. Beats once wr_ptr == DEPTH are dropped and set limbuff_error; the eop beat still closes the packet. limbuff_count keeps its old value until eop.
- iter_new_signal in IDLE with limbuff_count > 0 -> PRIME; read address 0 issued. Ignored when count == 0 or in LOAD.
- PRIME (1 cycle): limbuff_valid 0 -> REPLAY next cycle with limbuff_data = mem[0], limbuff_valid 1. Latency is 2 cycles from the iter pulse to valid.
- REPLAY: advance = adv_valid & adv_ready. RAM read address = advance ? rd_ptr+1 : rd_ptr, registered output, so there is no bubble between consecutive advances. limbuff_data holds while there is no advance.
- Advance on the last entry (rd_ptr == count-1): next cycle limbuff_valid 0, state IDLE.
- iter_new_signal in REPLAY restarts via PRIME (valid 0 for 1 cycle) and takes priority over a same-cycle advance.
- limbuff_valid == 0 means no limits: the consumer qualifies samples with it. The controller never blocks adv_ready.

Test Plan:
- Load 4 beats {max,min} = {100,-100},{50,-50},{10,-10},{0,0} with sop/eop, then pulse iter and advance every cycle -> limbuff_count=4; valid 2 cycles after the pulse; data follows entries 0..3 on consecutive cycles; valid drops the cycle after the 4th advance.
- Same load, advances with adv_ready low on alternate cycles -> each entry holds until its handshake; no entry skipped or repeated.
- ADDR_WIDTH=2, 6-beat packet -> entries 0..3 stored, beats 5-6 dropped, limbuff_error=1, count=4. A new sop beat clears the error.
- Pulse iter after the 2nd advance of a 4-entry replay, with advance in the same cycle -> valid 0 for 1 cycle, then entry 0 is presented again.
- Reset asserted mid-REPLAY -> next cycle limbuff_valid=0, count=0, load_ready=0 during reset. An iter pulse after reset is ignored until a packet is loaded.
- Beat without sop in IDLE, and iter pulse while in LOAD -> both ignored; count unchanged.

Source files
------------

// File: rtl/limits_buffer_ctrl.sv
// Limits buffer controller: stores one packet of {max,min} limit pairs and
// replays them in lock-step with the FIR samples consumed by the hard limiter.
module limits_buffer_ctrl #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           load_data,
    input  logic                  load_valid,
    input  logic                  load_sop,
    input  logic                  load_eop,
    output logic                  load_ready,
    input  logic                  iter_new_signal,
    input  logic                  adv_valid,
    input  logic                  adv_ready,
    output logic [31:0]           limbuff_data,
    output logic                  limbuff_valid,
    output logic [ADDR_WIDTH:0]   limbuff_count,
    output logic                  limbuff_error
);

    localparam int unsigned         DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, PRIME, REPLAY} state_t;

    state_t                 state;
    state_t                 state_next;

    logic [31:0]            mem [DEPTH];
    logic [ADDR_WIDTH:0]    wr_ptr;
    logic [ADDR_WIDTH-1:0]  rd_ptr;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [ADDR_WIDTH-1:0]  mem_wa;
    logic                   mem_we;

    logic                   beat;
    logic                   start_pkt;
    logic                   room;
    logic                   advance;
    logic                   last_entry;
    logic                   iter_start;

    assign beat       = load_valid & load_ready;
    assign start_pkt  = beat & load_sop;
    assign room       = (wr_ptr < DEPTH_W);
    assign advance    = adv_valid & adv_ready;
    assign last_entry = ({1'b0, rd_ptr} == (limbuff_count - ONE));
    // A sop beat in IDLE wins over a same-cycle iter pulse so the beat is never lost.
    assign iter_start = iter_new_signal &
                        (((state == IDLE) & ~start_pkt & (limbuff_count != '0)) |
                         (state == REPLAY));

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_pkt)       state_next = load_eop ? IDLE : LOAD;
                else if (iter_start) state_next = PRIME;
            end
            LOAD: begin
                if (beat & load_eop) state_next = IDLE;
            end
            PRIME:   state_next = REPLAY;
            REPLAY: begin
                if (iter_new_signal)          state_next = PRIME;
                else if (advance & last_entry) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        load_ready    = ~reset & ((state == IDLE) | (state == LOAD));
        limbuff_valid = (state == REPLAY);
    end

    // Load bookkeeping: write pointer, completed-packet count, overflow flag
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr        <= '0;
            limbuff_count <= '0;
            limbuff_error <= 1'b0;
        end else if (beat) begin
            if (load_sop) begin
                wr_ptr        <= ONE;
                limbuff_error <= 1'b0;
                if (load_eop) limbuff_count <= ONE;
            end else if (state == LOAD) begin
                if (room) wr_ptr        <= wr_ptr + ONE;
                else      limbuff_error <= 1'b1;
                // Once full, wr_ptr already equals DEPTH, which is the saturated count.
                if (load_eop) limbuff_count <= room ? (wr_ptr + ONE) : wr_ptr;
            end
        end
    end

    // RAM write port address/enable
    always_comb begin
        mem_we = beat & (load_sop | ((state == LOAD) & room));
        mem_wa = load_sop ? '0 : wr_ptr[ADDR_WIDTH-1:0];
    end

    // RAM write port (contents are not reset)
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_wa] <= load_data;
    end

    // Read address looks one entry ahead on an advance so consecutive advances see no bubble
    always_comb begin
        rd_addr = rd_ptr;
        if (iter_start)                          rd_addr = '0;
        else if ((state == REPLAY) && advance)   rd_addr = rd_ptr + ADDR_WIDTH'(1);
    end

    // Registered read port and replay pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr       <= '0;
            limbuff_data <= '0;
        end else begin
            rd_ptr       <= rd_addr;
            limbuff_data <= mem[rd_addr];
        end
    end

endmodule
